// File: rtl/imem_loader_if.sv
// Instruction-memory line-read channel.
// A valid/ready request carries the 8-byte-aligned line address. The response
// is a single valid pulse with the 64-bit line, one pulse per accepted request.
//   mem_req_valid   loader -> memory   line read request
//   mem_req_ready   memory -> loader   request accepted
//   mem_req_addr    loader -> memory   line address (low 3 bits zero)
//   mem_resp_valid  memory -> loader   line data valid
//   mem_resp_data   memory -> loader   line data
interface imem_loader_if #(
    parameter int DATA_WIDTH = 64
) ();
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [DATA_WIDTH-1:0] mem_req_addr;
    logic                  mem_resp_valid;
    logic [63:0]           mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_addr,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction-fetch memory front end.
// Takes one word load at a time from the fetch unit, reads 64-bit lines from
// instruction memory, and returns the selected 32-bit word. The most recently
// filled line is kept so that sequential fetches within that line skip memory.
// A flush (branch redirect) kills the load in progress.
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   load_addr_i     word address from the fetch PC
//   load_en_i       load request, sampled only while load_busy_o is low
//   load_insn_o     returned word, held until the next load_rdy_o
//   load_busy_o     load in progress or result being presented
//   load_rdy_o      one-cycle pulse qualifying load_insn_o / load_fault_o
//   load_fault_o    misaligned address
//   flush_i         branch redirect, kills the outstanding load
//   mem             line-read channel (master side)
module imem_loader #(
    parameter int DATA_WIDTH = 64,
    parameter int LINE_BYTES = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] load_addr_i,
    input  logic                  load_en_i,
    output logic [31:0]           load_insn_o,
    output logic                  load_busy_o,
    output logic                  load_rdy_o,
    output logic                  load_fault_o,
    input  logic                  flush_i,
    imem_loader_if.master         mem
);
    localparam int OFF_BITS = $clog2(LINE_BYTES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t state, state_next;

    logic [DATA_WIDTH-1:OFF_BITS] req_tag;
    logic                         req_word;
    logic                         buf_valid;
    logic [DATA_WIDTH-1:OFF_BITS] buf_tag;
    logic [63:0]                  buf_data;
    logic                         rdy_pending;
    logic [31:0]                  pend_insn, held_insn;
    logic                         pend_fault, held_fault;

    logic misaligned, hit, accept, fill;

    function automatic logic [31:0] word_sel(input logic [63:0] line, input logic hi);
        return hi ? line[63:32] : line[31:0];
    endfunction

    assign misaligned = |load_addr_i[1:0];
    assign hit        = buf_valid && (load_addr_i[DATA_WIDTH-1:OFF_BITS] == buf_tag);
    assign accept     = (state == IDLE) && !rdy_pending && load_en_i && !flush_i;
    assign fill       = (state == WAIT) && mem.mem_resp_valid && !flush_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (accept && !misaligned && !hit) state_next = REQ;
            REQ: begin
                // A flush on the handshake cycle still leaves a response in flight.
                if (flush_i)                state_next = mem.mem_req_ready ? DROP : IDLE;
                else if (mem.mem_req_ready) state_next = WAIT;
            end
            WAIT: begin
                if (mem.mem_resp_valid) state_next = IDLE;
                else if (flush_i)       state_next = DROP;
            end
            DROP: if (mem.mem_resp_valid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // The result is held in pend_* until presented; it only becomes the
    // visible held value if the rdy cycle is not killed by a flush.
    always_comb begin
        mem.mem_req_valid = (state == REQ);
        mem.mem_req_addr  = {req_tag, {OFF_BITS{1'b0}}};
        load_busy_o       = (state != IDLE) || rdy_pending;
        load_rdy_o        = rdy_pending && !flush_i;
        load_insn_o       = load_rdy_o ? pend_insn  : held_insn;
        load_fault_o      = load_rdy_o ? pend_fault : held_fault;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_tag     <= '0;
            req_word    <= 1'b0;
            buf_valid   <= 1'b0;
            buf_tag     <= '0;
            buf_data    <= '0;
            rdy_pending <= 1'b0;
            pend_insn   <= '0;
            pend_fault  <= 1'b0;
            held_insn   <= '0;
            held_fault  <= 1'b0;
        end else begin
            rdy_pending <= 1'b0;
            if (accept) begin
                if (misaligned) begin
                    rdy_pending <= 1'b1;
                    pend_fault  <= 1'b1;
                    pend_insn   <= '0;
                end else if (hit) begin
                    rdy_pending <= 1'b1;
                    pend_fault  <= 1'b0;
                    pend_insn   <= word_sel(buf_data, load_addr_i[OFF_BITS-1]);
                end else begin
                    req_tag  <= load_addr_i[DATA_WIDTH-1:OFF_BITS];
                    req_word <= load_addr_i[OFF_BITS-1];
                end
            end
            if (fill) begin
                buf_valid   <= 1'b1;
                buf_tag     <= req_tag;
                buf_data    <= mem.mem_resp_data;
                rdy_pending <= 1'b1;
                pend_fault  <= 1'b0;
                pend_insn   <= word_sel(mem.mem_resp_data, req_word);
            end
            if (load_rdy_o) begin
                held_insn  <= pend_insn;
                held_fault <= pend_fault;
            end
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] load_addr;
    logic        load_en;
    logic        flush;
    logic [31:0] insn;
    logic        busy, rdy, fault;

    always #5 clk = ~clk;

    imem_loader_if #(.DATA_WIDTH(64)) mem_bus ();

    imem_loader #(.DATA_WIDTH(64), .LINE_BYTES(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .load_addr_i  (load_addr),
        .load_en_i    (load_en),
        .load_insn_o  (insn),
        .load_busy_o  (busy),
        .load_rdy_o   (rdy),
        .load_fault_o (fault),
        .flush_i      (flush),
        .mem          (mem_bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one-line buffer and last delivered result.
    bit          m_buf_valid;
    logic [63:0] m_buf_line;
    logic [63:0] m_buf_data;
    logic [31:0] m_last_insn;
    bit          m_last_fault;

    typedef struct {
        logic [63:0] addr;
        int          d;      // cycles with ready low before handshake
        int          lat;    // response cycles after handshake
        int          f;      // flush cycle after en (0 = none)
        logic [63:0] data;
        bit          exp_req;
        bit          exp_rdy;
        logic [31:0] exp_insn;
        bit          exp_fault;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        load_en = 1'b0;
        flush   = 1'b0;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
    endtask

    // Runs one load: en in cycle 0; memory grants the request d cycles after it
    // appears and answers lat cycles after the grant. Timing expectations are
    // derived as cycle numbers from those parameters.
    task automatic do_load(input logic [63:0] addr, input int d, input int lat, input int f,
                           input logic [63:0] data, output bit saw_req, output bit got_rdy,
                           output logic [31:0] got_insn, output bit got_fault);
        bit mis, hit, miss, hs, resp_now;
        int h, r, e, rdyc, vend;
        logic [63:0] line;
        logic [31:0] word;
        line = {addr[63:3], 3'b000};
        mis  = addr[1:0] != 2'b00;
        hit  = !mis && m_buf_valid && (m_buf_line == line);
        miss = !mis && !hit;
        h = 1 + d;
        r = h + lat;
        if (!miss) begin
            e = 2; vend = 0; hs = 0;
            rdyc = (f == 1) ? -1 : 1;
        end else begin
            vend = (f != 0 && f < h) ? f : h;
            hs   = (f == 0 || f >= h);
            if (f != 0 && f < h)       e = f + 1;
            else if (f != 0 && f <= r) e = r + 1;
            else                       e = r + 2;
            rdyc = (f != 0 && f <= r + 1) ? -1 : r + 1;
        end
        if (mis)      word = 32'h0;
        else if (hit) word = addr[2] ? m_buf_data[63:32] : m_buf_data[31:0];
        else          word = addr[2] ? data[63:32] : data[31:0];
        saw_req = 0; got_rdy = 0; got_insn = 32'h0; got_fault = 0;

        load_en = 1'b1; load_addr = addr; flush = 1'b0;
        mem_bus.mem_req_ready  = 1'b0;
        mem_bus.mem_resp_valid = 1'b0;
        mem_bus.mem_resp_data  = {$urandom, $urandom};
        @(negedge clk);
        chk("start_busy",  64'(busy), 64'(0));
        chk("start_rdy",   64'(rdy), 64'(0));
        chk("start_valid", 64'(mem_bus.mem_req_valid), 64'(0));
        chk("hold_insn",   64'(insn), 64'(m_last_insn));
        chk("hold_fault",  64'(fault), 64'(m_last_fault));
        @(posedge clk); #1;

        for (int k = 1; k < e; k++) begin
            resp_now  = miss && hs && (k == r);
            load_en   = 1'($urandom_range(0, 1));
            load_addr = {$urandom, $urandom};
            flush     = (k == f);
            mem_bus.mem_req_ready = miss && (k == h);
            // stray responses while idle or requesting must be ignored
            mem_bus.mem_resp_valid = resp_now ? 1'b1 :
                                     ((!miss || k < h) ? 1'($urandom_range(0, 1)) : 1'b0);
            mem_bus.mem_resp_data  = resp_now ? data : {$urandom, $urandom};
            @(negedge clk);
            if (mem_bus.mem_req_valid) saw_req = 1;
            chk("req_valid", 64'(mem_bus.mem_req_valid), 64'(miss && k <= vend));
            if (miss && k <= vend) chk("req_addr", mem_bus.mem_req_addr, line);
            chk("busy", 64'(busy), 64'(1));
            chk("rdy", 64'(rdy), 64'(k == rdyc));
            if (rdy) begin got_rdy = 1; got_insn = insn; got_fault = fault; end
            if (k == rdyc) begin
                chk("insn",  64'(insn), 64'(word));
                chk("fault", 64'(fault), 64'(mis));
            end
            @(posedge clk); #1;
        end
        idle_inputs();
        if (rdyc > 0) begin m_last_insn = word; m_last_fault = mis; end
        if (miss && (f == 0 || f > r)) begin
            m_buf_valid = 1; m_buf_line = line; m_buf_data = data;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1);
    end

    initial begin
        bit sr, gr, gf;
        logic [31:0] gi;
        logic [63:0] a;
        int d, lat, f;

        vecs[0] = '{64'h1000, 0, 1, 0, 64'hAAAA_BBBB_0000_0013, 1'b1, 1'b1, 32'h0000_0013, 1'b0};
        vecs[1] = '{64'h1004, 0, 1, 0, 64'h0,                   1'b0, 1'b1, 32'hAAAA_BBBB, 1'b0};
        vecs[2] = '{64'h1008, 0, 1, 0, 64'h1111_2222_3333_4444, 1'b1, 1'b1, 32'h3333_4444, 1'b0};
        vecs[3] = '{64'h2002, 0, 1, 0, 64'h0,                   1'b0, 1'b1, 32'h0000_0000, 1'b1};
        vecs[4] = '{64'h3000, 3, 2, 5, 64'h0000_0000_0000_DEAD, 1'b1, 1'b0, 32'h0,         1'b0};
        vecs[5] = '{64'h3004, 0, 1, 0, 64'h7777_8888_9999_0000, 1'b1, 1'b1, 32'h7777_8888, 1'b0};
        vecs[6] = '{64'h4000, 2, 1, 1, 64'h0,                   1'b1, 1'b0, 32'h0,         1'b0};
        vecs[7] = '{64'h5000, 0, 2, 3, 64'h5555_5555_5555_5555, 1'b1, 1'b0, 32'h0,         1'b0};
        vecs[8] = '{64'h3000, 0, 1, 0, 64'h0,                   1'b0, 1'b1, 32'h9999_0000, 1'b0};
        vecs[9] = '{64'h3004, 0, 1, 1, 64'h0,                   1'b0, 1'b0, 32'h0,         1'b0};

        m_buf_valid = 0; m_buf_line = '0; m_buf_data = '0;
        m_last_insn = '0; m_last_fault = 0;
        rst = 1'b0; load_addr = '0; mem_bus.mem_resp_data = '0;
        idle_inputs();
        #12;
        chk("rst_busy",  64'(busy), 64'(0));
        chk("rst_rdy",   64'(rdy), 64'(0));
        chk("rst_fault", 64'(fault), 64'(0));
        chk("rst_insn",  64'(insn), 64'(0));
        chk("rst_valid", 64'(mem_bus.mem_req_valid), 64'(0));
        chk("rst_addr",  mem_bus.mem_req_addr, 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            do_load(vecs[i].addr, vecs[i].d, vecs[i].lat, vecs[i].f, vecs[i].data, sr, gr, gi, gf);
            chk($sformatf("tbl%0d_req", i), 64'(sr), 64'(vecs[i].exp_req));
            chk($sformatf("tbl%0d_rdy", i), 64'(gr), 64'(vecs[i].exp_rdy));
            if (vecs[i].exp_rdy) begin
                chk($sformatf("tbl%0d_insn", i),  64'(gi), 64'(vecs[i].exp_insn));
                chk($sformatf("tbl%0d_fault", i), 64'(gf), 64'(vecs[i].exp_fault));
            end
        end

        // load_en coincident with flush is ignored
        load_en = 1'b1; load_addr = 64'h7000; flush = 1'b1;
        @(negedge clk);
        chk("flush_en_busy0", 64'(busy), 64'(0));
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        chk("flush_en_busy1",  64'(busy), 64'(0));
        chk("flush_en_valid1", 64'(mem_bus.mem_req_valid), 64'(0));
        chk("flush_en_rdy1",   64'(rdy), 64'(0));
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            a = 64'h1000 + 64'(8 * $urandom_range(0, 5)) + 64'(4 * $urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = a + 64'($urandom_range(1, 3));
            d   = int'($urandom_range(0, 3));
            lat = int'($urandom_range(1, 3));
            f   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2 + d + lat)) : 0;
            do_load(a, d, lat, f, {$urandom, $urandom}, sr, gr, gi, gf);
        end

        // asynchronous reset while waiting for a response
        load_en = 1'b1; load_addr = 64'h6000;
        @(negedge clk);
        chk("ar_idle", 64'(busy), 64'(0));
        @(posedge clk); #1;
        load_en = 1'b0; mem_bus.mem_req_ready = 1'b1;
        @(negedge clk);
        chk("ar_valid", 64'(mem_bus.mem_req_valid), 64'(1));
        chk("ar_addr",  mem_bus.mem_req_addr, 64'h6000);
        @(posedge clk); #1;
        mem_bus.mem_req_ready = 1'b0;
        @(negedge clk);
        chk("ar_wait_valid", 64'(mem_bus.mem_req_valid), 64'(0));
        chk("ar_wait_busy",  64'(busy), 64'(1));
        #2 rst = 1'b0;
        #1;
        chk("ar_busy",  64'(busy), 64'(0));
        chk("ar_rdy",   64'(rdy), 64'(0));
        chk("ar_fault", 64'(fault), 64'(0));
        chk("ar_insn",  64'(insn), 64'(0));
        chk("ar_valid0", 64'(mem_bus.mem_req_valid), 64'(0));
        chk("ar_addr0", mem_bus.mem_req_addr, 64'(0));
        @(posedge clk); #1;
        rst = 1'b1;
        mem_bus.mem_resp_valid = 1'b1; mem_bus.mem_resp_data = 64'hFFFF_0000_0000_DEAD;
        @(negedge clk);
        chk("stray_busy", 64'(busy), 64'(0));
        chk("stray_rdy",  64'(rdy), 64'(0));
        @(posedge clk); #1;
        idle_inputs();
        m_buf_valid = 0; m_last_insn = '0; m_last_fault = 0;
        do_load(64'h1000, 0, 1, 0, 64'h0123_4567_89AB_CDEF, sr, gr, gi, gf);
        chk("post_rst_miss", 64'(sr), 64'(1));
        chk("post_rst_insn", 64'(gi), 64'h89AB_CDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
